regfile_seq_engine: RTL and testbench

- Initiator-side master for the 32x64 RegisterFile port set (RA, RB, RW, BusW, RegWr in; BusA, BusB out).
- LOAD mode: streams a contiguous register range in from a valid/ready source.
- DUMP mode: streams a range out, reading two registers per access via RA/RB.
- Used for debug/boot initialisation and for context save/restore of the architectural registers.

---
 rtl/regseq_pkg.sv | 20 ++
 rtl/regseq_if.sv | 49 ++++
 rtl/regseq_pair_buf.sv | 76 +++++++
 rtl/regfile_seq_engine.sv | 199 +++++++++++++++++++
 tb/tb_regfile_seq_engine.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regseq_pkg.sv
// Shared types and defaults for the register-file sequencing engine.
// Checksum accumulation is enabled by defining REGSEQ_CHECKSUM_EN.
package regseq_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/regseq_if.sv
// Command, stream and RegisterFile port bundle of the sequencing engine.
// master = engine side, slave = environment (command source, streams, RegisterFile).
interface regseq_if
  import regseq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              Start;
  logic              Mode;
  logic [ADDR_W-1:0] FirstReg;
  logic [ADDR_W-1:0] LastReg;
  logic              Busy;
  logic              Done;
  logic              Error;

  logic [DATA_W-1:0] InData;
  logic              InValid;
  logic              InReady;

  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutTag;
  logic              OutValid;
  logic              OutReady;

  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;
  logic              RegWr;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;

  logic [DATA_W-1:0] Checksum;

  modport master (
    input  Start, Mode, FirstReg, LastReg, InData, InValid, OutReady, BusA, BusB,
    output Busy, Done, Error, InReady, OutData, OutTag, OutValid,
           RA, RB, RW, BusW, RegWr, Checksum
  );

  modport slave (
    output Start, Mode, FirstReg, LastReg, InData, InValid, OutReady, BusA, BusB,
    input  Busy, Done, Error, InReady, OutData, OutTag, OutValid,
           RA, RB, RW, BusW, RegWr, Checksum
  );

endinterface

// File: rtl/regseq_pair_buf.sv
// Two-entry capture buffer holding one RA/RB read pair for the dump stream.
// head selects the entry on offer; last flags the final valid entry of the pair.
module regseq_pair_buf
  import regseq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data0,
  input  logic [DATA_W-1:0] cap_data1,
  input  logic              cap_valid1,
  input  logic [ADDR_W-1:0] cap_base,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] tag,
  output logic              last
);

  logic [DATA_W-1:0] cap_data [2];
  logic              head_q, head_d;
  logic              valid1_q, valid1_d;
  logic [ADDR_W-1:0] base_q, base_d;

  assign cap_data[0] = cap_data0;
  assign cap_data[1] = cap_data1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ent
      logic [DATA_W-1:0] ent_q, ent_d;

      assign ent_d = capture ? cap_data[gi] : ent_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_q <= '0;
        end else begin
          ent_q <= ent_d;
        end
      end
    end
  endgenerate

  always_comb begin
    head_d   = head_q;
    valid1_d = valid1_q;
    base_d   = base_q;
    if (capture) begin
      head_d   = 1'b0;
      valid1_d = cap_valid1;
      base_d   = cap_base;
    end else if (pop && !last) begin
      head_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= 1'b0;
      valid1_q <= 1'b0;
      base_q   <= '0;
    end else begin
      head_q   <= head_d;
      valid1_q <= valid1_d;
      base_q   <= base_d;
    end
  end

  assign data = head_q ? g_ent[1].ent_q : g_ent[0].ent_q;
  assign tag  = base_q + ADDR_W'(head_q);
  assign last = head_q | ~valid1_q;

endmodule

// File: rtl/regfile_seq_engine.sv
// Loads a register range from a valid/ready stream or dumps it two registers per read.
// Optional REGSEQ_CHECKSUM_EN adds an XOR checksum of every handshaked beat.
module regfile_seq_engine
  import regseq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input logic      Clk,
  input logic      ResetL,
  regseq_if.master bus
);

  localparam int PW = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic              regwr_q, regwr_d;
  logic              error_q, error_d;

  logic              start_ok;
  logic              in_hs;
  logic              out_hs;
  logic              capture;
  logic              valid1;
  logic              buf_last;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_tag;
  logic [PW-1:0]     ptr_p1, ptr_p2, last_ext;

  // Pointer arithmetic is one bit wider so LastReg at the top index ends without wrapping.
  assign last_ext = {1'b0, last_q};
  assign ptr_p1   = ptr_q + PW'(1);
  assign ptr_p2   = ptr_q + PW'(2);
  assign valid1   = (ptr_p1 <= last_ext);

  assign start_ok = (state_q == IDLE) && bus.Start && (bus.FirstReg <= bus.LastReg);
  assign in_hs    = (state_q == LOAD) && bus.InValid;
  assign out_hs   = (state_q == OUT) && bus.OutReady;
  assign capture  = (state_q == RD);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    regwr_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (!start_ok) begin
            error_d = 1'b1;
          end else begin
            ptr_d  = {1'b0, bus.FirstReg};
            last_d = bus.LastReg;
            if (bus.Mode == MODE_LOAD) begin
              state_d = LOAD;
            end else begin
              // Addresses are registered, so they are set up on entry to RD.
              state_d = RD;
              ra_d    = bus.FirstReg;
              rb_d    = bus.FirstReg + ADDR_W'(1);
            end
          end
        end
      end

      LOAD: begin
        if (in_hs) begin
          rw_d    = ptr_q[ADDR_W-1:0];
          busw_d  = bus.InData;
          regwr_d = (ptr_q != PW'(ZERO_REG));
          ptr_d   = ptr_p1;
          if (ptr_q == last_ext) begin
            state_d = FIN;
          end
        end
      end

      RD: begin
        state_d = OUT;
      end

      OUT: begin
        if (out_hs && buf_last) begin
          ptr_d = ptr_p2;
          if (ptr_p2 <= last_ext) begin
            state_d = RD;
            ra_d    = ptr_p2[ADDR_W-1:0];
            rb_d    = ptr_p2[ADDR_W-1:0] + ADDR_W'(1);
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rw_q    <= '0;
      busw_q  <= '0;
      regwr_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      regwr_q <= regwr_d;
      error_q <= error_d;
    end
  end

  regseq_pair_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_pair_buf (
    .clk       (Clk),
    .rst_n     (ResetL),
    .capture   (capture),
    .cap_data0 (bus.BusA),
    .cap_data1 (bus.BusB),
    .cap_valid1(valid1),
    .cap_base  (ptr_q[ADDR_W-1:0]),
    .pop       (out_hs),
    .data      (buf_data),
    .tag       (buf_tag),
    .last      (buf_last)
  );

`ifdef REGSEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (in_hs) begin
      csum_d = csum_q ^ bus.InData;
    end else if (out_hs) begin
      csum_d = csum_q ^ buf_data;
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.Checksum = csum_q;
`else
  assign bus.Checksum = '0;
`endif

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == FIN);
  assign bus.Error    = error_q;
  assign bus.InReady  = (state_q == LOAD);
  assign bus.OutValid = (state_q == OUT);
  assign bus.OutData  = buf_data;
  assign bus.OutTag   = buf_tag;
  assign bus.RA       = ra_q;
  assign bus.RB       = rb_q;
  assign bus.RW       = rw_q;
  assign bus.BusW     = busw_q;
  assign bus.RegWr    = regwr_q;

endmodule

// File: tb/tb_regfile_seq_engine.sv
// Randomised self-checking bench for regfile_seq_engine with a behavioural RegisterFile.
// Build with REGSEQ_CHECKSUM_EN defined to check the checksum feature as well.
module tb_regfile_seq_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regseq_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_seq_engine dut (
    .Clk   (clk),
    .ResetL(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] rf_mem   [32];
  logic [63:0] ref_rf   [32];
  logic [63:0] load_data[32];
  logic [68:0] wr_obs[$];
  int regwr_cnt = 0;
  int done_cnt  = 0;
  int n_checks  = 0;
  int n_errors  = 0;

  // RegisterFile: combinational read, negedge write, X31 hardwired to zero.
  assign bus.BusA = (bus.RA == 5'd31) ? 64'd0 : rf_mem[bus.RA];
  assign bus.BusB = (bus.RB == 5'd31) ? 64'd0 : rf_mem[bus.RB];

  always @(negedge clk) begin
    if (bus.RegWr) begin
      wr_obs.push_back({bus.RW, bus.BusW});
      regwr_cnt = regwr_cnt + 1;
      if (bus.RW != 5'd31) rf_mem[bus.RW] = bus.BusW;
    end
    if (bus.Done) done_cnt = done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_csum(input logic [63:0] x);
`ifdef REGSEQ_CHECKSUM_EN
    return x;
`else
    return 64'd0 & x;
`endif
  endfunction

  task automatic check_all_zero();
    check_val("rst_RA", 64'(bus.RA), 0);
    check_val("rst_RB", 64'(bus.RB), 0);
    check_val("rst_RW", 64'(bus.RW), 0);
    check_val("rst_BusW", bus.BusW, 0);
    check_val("rst_RegWr", 64'(bus.RegWr), 0);
    check_val("rst_InReady", 64'(bus.InReady), 0);
    check_val("rst_OutValid", 64'(bus.OutValid), 0);
    check_val("rst_OutData", bus.OutData, 0);
    check_val("rst_OutTag", 64'(bus.OutTag), 0);
    check_val("rst_Done", 64'(bus.Done), 0);
    check_val("rst_Error", 64'(bus.Error), 0);
    check_val("rst_Busy", 64'(bus.Busy), 0);
    check_val("rst_Checksum", bus.Checksum, 0);
  endtask

  task automatic issue_start(input logic mode, input int first, input int last);
    @(posedge clk); #1;
    bus.Start    = 1'b1;
    bus.Mode     = mode;
    bus.FirstReg = 5'(first);
    bus.LastReg  = 5'(last);
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic run_load(input int first, input int last, input int pre_idle, input int valid_pct);
    logic [68:0] exp_wr[$];
    logic [63:0] csum;
    int idx, cyc, d0;
    bit hs;
    csum = '0;
    d0 = done_cnt;
    wr_obs.delete();
    issue_start(1'b1, first, last);
    check_val("load_busy", 64'(bus.Busy), 1);
    idx = first;
    cyc = 0;
    while (idx <= last && cyc < 4000) begin
      bus.InValid = (cyc >= pre_idle) && ($urandom_range(99) < valid_pct);
      bus.InData  = bus.InValid ? load_data[idx] : {$urandom, $urandom};
      hs = bus.InValid && bus.InReady;
      @(posedge clk); #1;
      if (hs) begin
        csum ^= load_data[idx];
        if (idx != 31) begin
          ref_rf[idx] = load_data[idx];
          exp_wr.push_back({5'(idx), load_data[idx]});
        end
        idx++;
      end
      cyc++;
    end
    bus.InValid = 1'b0;
    check_val("load_beats", 64'(idx), 64'(last + 1));
    check_val("load_done", 64'(bus.Done), 1);
    check_val("load_inready_off", 64'(bus.InReady), 0);
    check_val("load_csum", bus.Checksum, exp_csum(csum));
    @(posedge clk); #1;
    check_val("load_idle", 64'({bus.Busy, bus.Done}), 0);
    check_val("load_done_cnt", 64'(done_cnt - d0), 1);
    check_val("load_wr_cnt", 64'(wr_obs.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_obs.size(); i++) begin
      check_val("load_wr_addr", 64'(wr_obs[i][68:64]), 64'(exp_wr[i][68:64]));
      check_val("load_wr_data", wr_obs[i][63:0], exp_wr[i][63:0]);
    end
    $display("load  %0d..%0d: %0d beats in %0d cycles, %0d writes", first, last,
             idx - first, cyc, wr_obs.size());
  endtask

  task automatic run_dump(input int first, input int last, input int ready_mode);
    logic [63:0] csum, prev_data;
    logic [4:0]  prev_tag;
    int idx, cyc, d0, w0, ra_seen, n;
    bit hs, stalled;
    csum = '0;
    d0 = done_cnt;
    w0 = regwr_cnt;
    ra_seen = -1;
    stalled = 0;
    prev_data = '0;
    prev_tag = '0;
    issue_start(1'b0, first, last);
    check_val("dump_busy", 64'(bus.Busy), 1);
    idx = first;
    cyc = 0;
    while (idx <= last && cyc < 4000) begin
      if (bus.OutValid) begin
        check_val("dump_tag", 64'(bus.OutTag), 64'(idx));
        check_val("dump_data", bus.OutData, ref_rf[idx]);
        if (((idx - first) % 2) == 0 && ra_seen != idx) begin
          check_val("dump_RA", 64'(bus.RA), 64'(idx));
          check_val("dump_RB", 64'(bus.RB), 64'((idx + 1) % 32));
          ra_seen = idx;
        end
        if (stalled) begin
          check_val("dump_hold_data", bus.OutData, prev_data);
          check_val("dump_hold_tag", 64'(bus.OutTag), 64'(prev_tag));
        end
      end
      case (ready_mode)
        0:       bus.OutReady = 1'b1;
        1:       bus.OutReady = ((cyc % 3) == 0);
        default: bus.OutReady = 1'($urandom_range(1));
      endcase
      hs = bus.OutValid && bus.OutReady;
      stalled = bus.OutValid && !bus.OutReady;
      prev_data = bus.OutData;
      prev_tag = bus.OutTag;
      @(posedge clk); #1;
      if (hs) begin
        csum ^= ref_rf[idx];
        idx++;
      end
      cyc++;
    end
    bus.OutReady = 1'b0;
    n = last - first + 1;
    check_val("dump_beats", 64'(idx), 64'(last + 1));
    if (ready_mode == 0) check_val("dump_cycles", 64'(cyc), 64'(3 * (n / 2) + 2 * (n % 2)));
    check_val("dump_done", 64'(bus.Done), 1);
    check_val("dump_outvalid_off", 64'(bus.OutValid), 0);
    check_val("dump_csum", bus.Checksum, exp_csum(csum));
    @(posedge clk); #1;
    check_val("dump_idle", 64'({bus.Busy, bus.Done, bus.OutValid}), 0);
    check_val("dump_done_cnt", 64'(done_cnt - d0), 1);
    check_val("dump_no_regwr", 64'(regwr_cnt - w0), 0);
    $display("dump  %0d..%0d: %0d beats in %0d cycles", first, last, idx - first, cyc);
  endtask

  task automatic run_error(input int first, input int last);
    int d0, w0;
    d0 = done_cnt;
    w0 = regwr_cnt;
    issue_start(1'($urandom_range(1)), first, last);
    check_val("err_pulse", 64'(bus.Error), 1);
    check_val("err_busy", 64'(bus.Busy), 0);
    @(posedge clk); #1;
    check_val("err_pulse_end", 64'({bus.Error, bus.Busy}), 0);
    check_val("err_no_regwr", 64'(regwr_cnt - w0), 0);
    check_val("err_no_done", 64'(done_cnt - d0), 0);
    $display("error %0d..%0d: rejected", first, last);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 32; i++) load_data[i] = {$urandom, $urandom};
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start    = 1'b0;
    bus.Mode     = 1'b0;
    bus.FirstReg = '0;
    bus.LastReg  = '0;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.OutReady = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      ref_rf[i] = '0;
    end

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst_n = 1'b1;

    // Full-range load then dump; X31 must never be written.
    for (int i = 0; i < 32; i++) load_data[i] = 64'(i + 'h100);
    run_load(0, 31, 0, 70);
    run_dump(0, 31, 0);

    run_error(9, 4);

    run_dump(10, 12, 1);

    load_data[5] = 64'hABCD;
    run_load(5, 5, 4, 100);
    run_dump(5, 5, 0);

    // Reset after two committed beats of a six-beat load.
    randomize_data();
    issue_start(1'b1, 20, 25);
    bus.InValid = 1'b1;
    bus.InData  = load_data[20];
    @(posedge clk); #1;
    bus.InData  = load_data[21];
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    ref_rf[20] = load_data[20];
    ref_rf[21] = load_data[21];
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset during load 20..25 after 2 beats");
    run_dump(20, 25, 2);

    load_data[1] = 64'hF0;
    load_data[2] = 64'h0F;
    load_data[3] = 64'hFF;
    run_load(1, 3, 0, 100);
    run_dump(0, 4, 0);

    for (int it = 0; it < 30; it++) begin
      int f, l, a;
      f = $urandom_range(31);
      l = $urandom_range(31, f);
      if ($urandom_range(7) == 0) begin
        a = $urandom_range(31, 1);
        run_error(a, $urandom_range(a - 1, 0));
      end else if ($urandom_range(1) == 1) begin
        randomize_data();
        run_load(f, l, $urandom_range(3), $urandom_range(100, 40));
      end else begin
        run_dump(f, l, 2);
      end
    end
    run_dump(0, 31, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
